// File: rtl/alu_pkg.sv
// Shared opcode/state types for the sequential ALU and its iterative multiply/divide unit.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD   = 4'h0,
      OP_SUB   = 4'h1,
      OP_AND   = 4'h2,
      OP_OR    = 4'h3,
      OP_XOR   = 4'h4,
      OP_SLTU  = 4'h5,
      OP_SLL   = 4'h6,
      OP_SLT   = 4'h7,
      OP_SRL   = 4'h8,
      OP_SRA   = 4'h9,
      OP_MUL   = 4'hA,
      OP_MULHU = 4'hB,
      OP_DIVU  = 4'hC,
      OP_REMU  = 4'hD,
      OP_ILL_E = 4'hE,
      OP_ILL_F = 4'hF
   } op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic is_multicycle(op_t op);
      return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle between register-read, the sequential ALU and writeback.
interface seq_alu_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       op;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             carry;
   logic             overflow;
   logic             illegal;

   modport master (
      output in_valid, op, src_a, src_b, flush, out_ready,
      input  in_ready, out_valid, result, zero, carry, overflow, illegal
   );

   modport slave (
      input  in_valid, op, src_a, src_b, flush, out_ready,
      output in_ready, out_valid, result, zero, carry, overflow, illegal
   );
endinterface

// File: rtl/seq_muldiv_unit.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one step per cycle.
module seq_muldiv_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  op_t              op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);
   localparam int CW = $clog2(WIDTH) + 1;

   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
   op_t              op_q, op_d;
   logic [WIDTH:0]   sum, rem_sh, diff;
   logic             ge;

   assign busy = (cnt_q != '0);

   // hi/lo hold {product high, multiplier} for MUL and {remainder, dividend/quotient} for DIV
   always_comb begin
      sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      rem_sh = {hi_q, lo_q[WIDTH-1]};
      diff   = rem_sh - {1'b0, b_q};
      ge     = (rem_sh >= {1'b0, b_q});
      cnt_d  = cnt_q;
      hi_d   = hi_q;
      lo_d   = lo_q;
      b_d    = b_q;
      op_d   = op_q;
      if (flush) begin
         cnt_d = '0;
      end else if (start) begin
         cnt_d = CW'(WIDTH);
         hi_d  = '0;
         lo_d  = a;
         b_d   = b;
         op_d  = op;
      end else if (busy) begin
         cnt_d = cnt_q - CW'(1);
         if ((op_q == OP_MUL) || (op_q == OP_MULHU)) begin
            {hi_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
         end else begin
            hi_d = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], ge};
         end
      end
      done   = busy && !flush && (cnt_q == CW'(1));
      result = ((op_q == OP_MUL) || (op_q == OP_DIVU)) ? lo_d : hi_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
         b_q   <= '0;
         op_q  <= OP_ADD;
      end else begin
         cnt_q <= cnt_d;
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         b_q   <= b_d;
         op_q  <= op_d;
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle arithmetic/logic/shift datapath plus optional iterative MUL/DIV.
module seq_alu
   import alu_pkg::*;
#(
   parameter  int WIDTH     = 32,
   parameter  bit MULDIV_EN = 1'b1,
   localparam int SHW       = $clog2(WIDTH)
) (
   input  logic      clk,
   input  logic      rst_n,
   seq_alu_if.slave  bus
);
   state_t           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d, carry_q, carry_d, overflow_q, overflow_d, illegal_q, illegal_d;

   op_t              op_in;
   logic [WIDTH-1:0] a, b;
   logic [SHW-1:0]   shamt;
   logic [WIDTH:0]   add_w, sub_w;
   logic [WIDTH-1:0] sc_result, ld_result, md_result;
   logic             sc_carry, sc_ov, ld_carry, ld_ov, ld_ill;
   logic             illegal_op, div_zero, in_ready_w, accept, start_md, md_flush, md_busy, md_done;

   assign op_in = op_t'(bus.op);
   assign a     = bus.src_a;
   assign b     = bus.src_b;
   assign shamt = b[SHW-1:0];

   assign illegal_op = (op_in == OP_ILL_E) || (op_in == OP_ILL_F) || (is_multicycle(op_in) && !MULDIV_EN);
   assign div_zero   = ((op_in == OP_DIVU) || (op_in == OP_REMU)) && (b == '0) && MULDIV_EN;
   // a flush in DONE also blocks the back-to-back accept
   assign in_ready_w = ((state_q == IDLE) && !md_busy) ||
                       ((state_q == DONE) && bus.out_ready && !bus.flush);
   assign accept     = bus.in_valid && in_ready_w;
   assign start_md   = accept && is_multicycle(op_in) && !illegal_op && !div_zero;
   assign md_flush   = bus.flush && (state_q != IDLE);

   always_comb begin
      add_w     = {1'b0, a} + {1'b0, b};
      sub_w     = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
      sc_result = '0;
      sc_carry  = 1'b0;
      sc_ov     = 1'b0;
      case (op_in)
         OP_ADD: begin
            sc_result = add_w[WIDTH-1:0];
            sc_carry  = add_w[WIDTH];
            sc_ov     = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            sc_result = sub_w[WIDTH-1:0];
            sc_carry  = sub_w[WIDTH];
            sc_ov     = (a[WIDTH-1] == ~b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  sc_result = a & b;
         OP_OR:   sc_result = a | b;
         OP_XOR:  sc_result = a ^ b;
         OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLL:  sc_result = a << shamt;
         OP_SRL:  sc_result = a >> shamt;
         OP_SRA:  sc_result = $signed(a) >>> shamt;
         default: sc_result = '0;
      endcase

      ld_result = sc_result;
      ld_carry  = sc_carry;
      ld_ov     = sc_ov;
      ld_ill    = 1'b0;
      if (illegal_op) begin
         ld_result = '0;
         ld_carry  = 1'b0;
         ld_ov     = 1'b0;
         ld_ill    = 1'b1;
      end else if (div_zero) begin
         ld_result = (op_in == OP_DIVU) ? '1 : a;
         ld_carry  = 1'b0;
         ld_ov     = 1'b0;
      end
   end

   generate
      if (MULDIV_EN) begin : g_md
         seq_muldiv_unit #(.WIDTH(WIDTH)) u_md (
            .clk    (clk),
            .rst_n  (rst_n),
            .start  (start_md),
            .op     (op_in),
            .a      (a),
            .b      (b),
            .flush  (md_flush),
            .busy   (md_busy),
            .done   (md_done),
            .result (md_result)
         );
      end else begin : g_no_md
         assign md_busy   = 1'b0;
         assign md_done   = 1'b0;
         assign md_result = '0;
      end
   endgenerate

   // accept wins first; otherwise flush, then iterative completion, then result drain
   always_comb begin
      state_d    = state_q;
      result_d   = result_q;
      zero_d     = zero_q;
      carry_d    = carry_q;
      overflow_d = overflow_q;
      illegal_d  = illegal_q;
      if (accept) begin
         if (start_md) begin
            state_d    = BUSY;
            result_d   = '0;
            zero_d     = 1'b0;
            carry_d    = 1'b0;
            overflow_d = 1'b0;
            illegal_d  = 1'b0;
         end else begin
            state_d    = DONE;
            result_d   = ld_result;
            zero_d     = !ld_ill && (ld_result == '0);
            carry_d    = ld_carry;
            overflow_d = ld_ov;
            illegal_d  = ld_ill;
         end
      end else if ((state_q != IDLE) && bus.flush) begin
         state_d    = IDLE;
         result_d   = '0;
         zero_d     = 1'b0;
         carry_d    = 1'b0;
         overflow_d = 1'b0;
         illegal_d  = 1'b0;
      end else if ((state_q == BUSY) && md_done) begin
         state_d    = DONE;
         result_d   = md_result;
         zero_d     = (md_result == '0);
         carry_d    = 1'b0;
         overflow_d = 1'b0;
         illegal_d  = 1'b0;
      end else if ((state_q == DONE) && bus.out_ready) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         result_q   <= '0;
         zero_q     <= 1'b0;
         carry_q    <= 1'b0;
         overflow_q <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         result_q   <= result_d;
         zero_q     <= zero_d;
         carry_q    <= carry_d;
         overflow_q <= overflow_d;
         illegal_q  <= illegal_d;
      end
   end

   assign bus.in_ready  = in_ready_w;
   assign bus.out_valid = (state_q == DONE);
   assign bus.result    = result_q;
   assign bus.zero      = zero_q;
   assign bus.carry     = carry_q;
   assign bus.overflow  = overflow_q;
   assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_seq_alu.sv
// Randomised and directed checks of seq_alu against an arithmetic reference model.
module tb_seq_alu;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   seq_alu_if #(.WIDTH(W)) bus ();
   seq_alu_if #(.WIDTH(W)) bus0 ();

   seq_alu #(.WIDTH(W), .MULDIV_EN(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   seq_alu #(.WIDTH(W), .MULDIV_EN(1'b0)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Expected result, flags and latency derived from plain integer arithmetic
   function automatic void refModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input bit md_en, output logic [31:0] r, output bit z, output bit c,
                                    output bit v, output bit ill, output int lat);
      longint      sa, sb, ss;
      logic [63:0] p;
      logic [32:0] uw;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r = '0; c = 0; v = 0; ill = 0; lat = 1;
      case (op)
         4'h0: begin uw = {1'b0, a} + {1'b0, b}; r = uw[31:0]; c = uw[32];
                     ss = sa + sb; v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648); end
         4'h1: begin r = a - b; c = (a >= b);
                     ss = sa - sb; v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648); end
         4'h2: r = a & b;
         4'h3: r = a | b;
         4'h4: r = a ^ b;
         4'h5: r = (a < b) ? 32'd1 : 32'd0;
         4'h6: r = a << b[4:0];
         4'h7: r = (sa < sb) ? 32'd1 : 32'd0;
         4'h8: r = a >> b[4:0];
         4'h9: r = $signed(a) >>> b[4:0];
         4'hA, 4'hB, 4'hC, 4'hD: begin
            if (!md_en) begin
               ill = 1;
            end else begin
               p = 64'(a) * 64'(b);
               lat = 33;
               case (op)
                  4'hA: r = p[31:0];
                  4'hB: r = p[63:32];
                  4'hC: if (b == 0) begin r = 32'hFFFF_FFFF; lat = 1; end else r = a / b;
                  default: if (b == 0) begin r = a; lat = 1; end else r = a % b;
               endcase
            end
         end
         default: ill = 1;
      endcase
      z = !ill && (r == 0);
   endfunction

   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
      logic [31:0] er;
      bit          ez, ec, ev, ei, rdy_busy;
      int          elat, lat;
      refModel(op, a, b, 1'b1, er, ez, ec, ev, ei, elat);
      bus.op = op; bus.src_a = a; bus.src_b = b;
      bus.in_valid = 1'b1; bus.out_ready = 1'b0;
      checkOutput($sformatf("in_ready op%0h", op), bus.in_ready, 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 1; rdy_busy = 0;
      while (!bus.out_valid && lat < 100) begin
         if (bus.in_ready) rdy_busy = 1;
         @(posedge clk); #1;
         lat++;
      end
      checkOutput($sformatf("latency op%0h", op), lat, elat);
      if (elat > 1) checkOutput($sformatf("in_ready_busy op%0h", op), rdy_busy, 0);
      repeat (hold) begin @(posedge clk); #1; end
      checkOutput($sformatf("in_ready_held op%0h", op), bus.in_ready, 0);
      checkOutput($sformatf("result op%0h a=%h b=%h", op, a, b), bus.result, er);
      if (!ei) checkOutput($sformatf("zero op%0h", op), bus.zero, ez);
      checkOutput($sformatf("carry op%0h", op), bus.carry, ec);
      checkOutput($sformatf("overflow op%0h", op), bus.overflow, ev);
      checkOutput($sformatf("illegal op%0h", op), bus.illegal, ei);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      checkOutput($sformatf("drained op%0h", op), bus.out_valid, 0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [3:0]  dir_op [10];
      logic [31:0] dir_a  [10];
      logic [31:0] dir_b  [10];
      logic [31:0] er, rb;
      bit          ez, ec, ev, ei, rose;
      int          elat;

      dir_op = '{4'h0, 4'h1, 4'hA, 4'hB, 4'hC, 4'hD, 4'hC, 4'hD, 4'hF, 4'h7};
      dir_a  = '{32'h7FFF_FFFF, 32'd5, 32'h0001_0000, 32'h0001_0000, 32'd100, 32'd100,
                 32'h1234, 32'h1234, 32'hDEAD_BEEF, 32'hFFFF_FFFF};
      dir_b  = '{32'h1, 32'd5, 32'h0001_0000, 32'h0001_0000, 32'd7, 32'd7, 32'd0, 32'd0, 32'h1, 32'h1};

      {bus.in_valid, bus.flush, bus.out_ready} = '0;
      bus.op = '0; bus.src_a = '0; bus.src_b = '0;
      {bus0.in_valid, bus0.flush, bus0.out_ready} = '0;
      bus0.op = '0; bus0.src_a = '0; bus0.src_b = '0;

      #12;
      checkOutput("reset out_valid", bus.out_valid, 0);
      checkOutput("reset result", bus.result, 0);
      checkOutput("reset in_ready", bus.in_ready, 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // async reset in the middle of a divide
      bus.op = 4'hC; bus.src_a = 32'd100; bus.src_b = 32'd7; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      checkOutput("midreset out_valid", bus.out_valid, 0);
      checkOutput("midreset result", bus.result, 0);
      checkOutput("midreset flags", {bus.zero, bus.carry, bus.overflow, bus.illegal}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      checkOutput("postreset in_ready", bus.in_ready, 1);
      checkOutput("postreset out_valid", bus.out_valid, 0);
      applyStimulus(4'h0, 32'd2, 32'd3, 0);

      $display("[TB] directed operations");
      for (int i = 0; i < 10; i++) applyStimulus(dir_op[i], dir_a[i], dir_b[i], i % 3);

      // backpressure then back-to-back accept from DONE
      bus.op = 4'h6; bus.src_a = 32'h1; bus.src_b = 32'd35; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checkOutput($sformatf("bp result c%0d", i), bus.result, 32'h8);
         checkOutput($sformatf("bp out_valid c%0d", i), bus.out_valid, 1);
         checkOutput($sformatf("bp in_ready c%0d", i), bus.in_ready, 0);
      end
      bus.out_ready = 1'b1; bus.in_valid = 1'b1;
      bus.op = 4'h9; bus.src_a = 32'h8000_0000; bus.src_b = 32'd4;
      #1;
      checkOutput("b2b in_ready", bus.in_ready, 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      checkOutput("b2b out_valid", bus.out_valid, 1);
      checkOutput("b2b result", bus.result, 32'hF800_0000);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;

      // flush a multiply in its tenth cycle
      bus.op = 4'hA; bus.src_a = 32'd1234; bus.src_b = 32'd5678; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      checkOutput("flush out_valid", bus.out_valid, 0);
      checkOutput("flush in_ready", bus.in_ready, 1);
      rose = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.out_valid) rose = 1;
      end
      checkOutput("flush never valid", rose, 0);
      applyStimulus(4'h4, 32'hF0F0_1234, 32'h0FF0_4321, 1);

      $display("[TB] random operations");
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 3))
            0:       rb = 32'd0;
            1:       rb = $urandom_range(1, 15);
            default: rb = $urandom;
         endcase
         applyStimulus(4'($urandom_range(0, 15)), $urandom, rb, $urandom_range(0, 2));
      end

      // variant without the multiply/divide unit
      for (int i = 0; i < 2; i++) begin
         bus0.op = (i == 0) ? 4'hA : 4'hC;
         bus0.src_a = 32'd3; bus0.src_b = (i == 0) ? 32'd4 : 32'd0;
         refModel(bus0.op, bus0.src_a, bus0.src_b, 1'b0, er, ez, ec, ev, ei, elat);
         bus0.in_valid = 1'b1;
         #1;
         checkOutput($sformatf("nomd in_ready %0d", i), bus0.in_ready, 1);
         @(posedge clk); #1;
         bus0.in_valid = 1'b0;
         checkOutput($sformatf("nomd out_valid %0d", i), bus0.out_valid, elat == 1);
         checkOutput($sformatf("nomd illegal %0d", i), bus0.illegal, ei);
         checkOutput($sformatf("nomd result %0d", i), bus0.result, er);
         bus0.out_ready = 1'b1;
         @(posedge clk); #1;
         bus0.out_ready = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked successor to the single-cycle datapath ALU.
- Executes arithmetic, logic and shift ops in one cycle.
- Executes multiply, divide and remainder iteratively.
- Sits between the decode/register-read stage and writeback. Stalls the pipeline through a valid/ready pair instead of assuming fixed one-cycle completion.

Parameters:
WIDTH, 32, operand/result width; ≥4, power of two
MULDIV_EN, 1, 1 = iterative MUL/DIV unit present; 0 = those opcodes take the illegal path
SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation request
in_ready  out  1  block can accept a request this cycle
op  in  4  opcode (see Behaviour)
src_a  in  WIDTH  operand A
src_b  in  WIDTH  operand B
flush  in  1  abort in-flight op, discard result
out_valid  out  1  result registered and valid
out_ready  in  1  consumer takes result
result  out  WIDTH  operation result
zero  out  1  result == 0
carry  out  1  ADD: carry-out; SUB: NOT borrow; else 0
overflow  out  1  signed overflow for ADD/SUB; else 0
illegal  out  1  undefined opcode, or MUL/DIV with MULDIV_EN=0

Behaviour:
- Opcodes (low codes keep legacy ALUControl numbering):
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR
  - 0101 SLTU (unsigned, legacy SLT semantics), 0110 SLL, 0111 SLT (signed)
  - 1000 SRL, 1001 SRA, 1010 MUL (low WIDTH bits), 1011 MULHU (high WIDTH bits, unsigned)
  - 1100 DIVU, 1101 REMU
  - 1110/1111 illegal
- Shifts use src_b[SHW-1:0] only.
- Reset (rst_n low, async): state IDLE; out_valid=0; result=0; zero=0; carry=0; overflow=0; illegal=0; iteration counter cleared. Applies mid-operation as well.
- Handshake:
  - Accept when in_valid && in_ready.
  - in_ready = (state==IDLE) || (state==DONE && out_ready), so back-to-back ops are accepted without a bubble.
  - Once out_valid is high, result and flags stay stable until the cycle out_ready is high.
- States:
  - IDLE:
    - Accept of a single-cycle op, an illegal op, or DIVU/REMU with src_b==0 → DONE. Result is registered at the accept edge, so out_valid is high the next cycle (latency 1).
    - Accept of MUL/MULHU/DIVU/REMU → BUSY, counter=WIDTH.
  - BUSY:
    - One shift-add (MUL) or restoring-subtract (DIV) step per cycle. Counter decrements.
    - At counter==1 the final step writes the result → DONE.
    - Iterative latency is WIDTH+1 cycles from the accept edge to out_valid.
    - in_ready=0 throughout.
  - DONE:
    - out_valid=1.
    - out_ready && !new accept → IDLE.
    - out_ready && new accept → behaves as an accept from IDLE.
- flush:
  - In BUSY or DONE: → IDLE next edge, out_valid=0, result discarded.
  - flush has priority over out_ready and over a same-cycle accept; the request is not accepted.
  - In IDLE: no effect.
- Arithmetic:
  - ADD/SUB computed at WIDTH+1 bits. carry = bit WIDTH.
  - overflow = (sign A == sign B') && (sign result != sign A), where B' = ~B for SUB.
  - SLT/SLTU return 1 or 0, zero-extended.
  - SRA replicates src_a[WIDTH-1].
- Divide by zero: DIVU → all ones; REMU → src_a; latency 1; illegal=0.
- illegal=1: result=0, other flags 0, latency 1.
- zero is computed from the registered result for every op.

Decomposition:
- Shared package alu_pkg:
  - op_t 4-bit opcode enum with the codes above
  - state_t {IDLE, BUSY, DONE}
  - function is_multicycle(op)
- Sub-module seq_muldiv_unit (WIDTH param):
  - Owns the counter, partial product / remainder registers and the step logic.
  - Interface: start, op, a, b, flush → busy, done pulse, result.
- Top level keeps the combinational single-cycle datapath, the FSM, output registers and flags.

Test Plan:
- rst_n asserted during BUSY of DIVU → all outputs 0 immediately. After release, in_ready=1, out_valid=0. Next ADD 2+3 → result 5 one cycle later.
- ADD 0x7FFFFFFF+0x00000001 → result 0x80000000, overflow=1, carry=0, zero=0. SUB 5−5 → result 0, zero=1, carry=1.
- MUL 0x00010000×0x00010000 → result 0; MULHU same operands → result 0x00000001. out_valid exactly 33 cycles after accept; in_ready=0 in between.
- DIVU 100/7 → 14; REMU 100/7 → 2. DIVU 0x1234/0 → 0xFFFFFFFF at latency 1. REMU 0x1234/0 → 0x1234.
- out_ready held low 3 cycles after SLL 0x1<<35 (shift 3) → result 0x8 stable, in_ready=0. Then out_ready=1 with in_valid=1 (SRA 0x80000000>>4) → accepted the same cycle; next result 0xF8000000.
- flush in cycle 10 of a MUL → out_valid never rises, IDLE next cycle. Opcode 1111 → illegal=1, result 0. With MULDIV_EN=0, MUL → illegal=1 at latency 1.
